// File: rtl/mu0_clock_ctrl.sv
// Run/clock controller for the mu0 core: derives the gated core clock from the
// selected source mode and owns the run-enable flag (start toggle / done / halt / step count).
module mu0_clock_ctrl #(
    parameter int CNT_W    = 32,
    parameter int STEP_W   = 16,
    parameter int SLOW_DIV = 6318000,
    parameter int CYC_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        clk_mode,
    input  logic              start,
    input  logic              done,
    input  logic              halt_req,
    input  logic [CNT_W-1:0]  slow_div,
    input  logic [STEP_W-1:0] step_count,
    output logic              core_clk,
    output logic              core_tick,
    output logic              enable,
    output logic              clk_src,
    output logic [STEP_W-1:0] steps_left,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              step_done
);

    localparam logic [3:0] MODE_OFF        = 4'd0;
    localparam logic [3:0] MODE_FAST       = 4'd1;
    localparam logic [3:0] MODE_SLOW       = 4'd2;
    localparam logic [3:0] MODE_MANUAL_OFF = 4'd3;
    localparam logic [3:0] MODE_MANUAL_ON  = 4'd4;
    localparam logic [3:0] MODE_STEP       = 4'd5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STEP_RUN = 2'd2;

    logic [1:0]        state_r;
    logic              start_q_r;
    logic [3:0]        mode_q_r;
    logic [CNT_W-1:0]  div_cnt_r;
    logic              clk_src_r;
    logic              core_clk_r;
    logic              core_tick_r;
    logic              enable_r;
    logic [STEP_W-1:0] steps_left_r;
    logic [CYC_W-1:0]  cycle_count_r;
    logic              step_done_r;

    logic [CNT_W-1:0]  div_d_s;
    logic              mode_chg_s;
    logic [CNT_W-1:0]  div_cnt_next_s;
    logic              clk_src_next_s;

    logic              req_s;
    logic              stop_s;
    logic              last_tick_s;
    logic [1:0]        state_next_s;
    logic [STEP_W-1:0] steps_next_s;
    logic              step_done_next_s;
    logic              enable_next_s;
    logic              core_clk_next_s;
    logic              rise_s;

    // Source clock generation: per-mode level rule plus the SLOW half-period divider.
    always_comb begin
        div_d_s        = (slow_div == {CNT_W{1'b0}}) ? CNT_W'(SLOW_DIV) : slow_div;
        mode_chg_s     = (clk_mode != mode_q_r);
        div_cnt_next_s = {CNT_W{1'b0}};
        clk_src_next_s = 1'b0;
        case (clk_mode)
            MODE_OFF, MODE_MANUAL_OFF: begin
                clk_src_next_s = 1'b0;
            end
            MODE_MANUAL_ON: begin
                clk_src_next_s = 1'b1;
            end
            MODE_FAST, MODE_STEP: begin
                clk_src_next_s = ~clk_src_r;
            end
            MODE_SLOW: begin
                // Entering SLOW restarts the count; >= also catches a divider shrunk mid-count.
                if (mode_chg_s) begin
                    div_cnt_next_s = {CNT_W{1'b0}};
                    clk_src_next_s = clk_src_r;
                end else if (div_cnt_r >= (div_d_s - CNT_W'(1))) begin
                    div_cnt_next_s = {CNT_W{1'b0}};
                    clk_src_next_s = ~clk_src_r;
                end else begin
                    div_cnt_next_s = div_cnt_r + CNT_W'(1);
                    clk_src_next_s = clk_src_r;
                end
            end
            default: begin
                clk_src_next_s = 1'b0;
            end
        endcase
    end

    // Run FSM: stop requests beat step exhaustion, which beats a new start request.
    always_comb begin
        req_s            = (start != start_q_r);
        stop_s           = done | halt_req;
        last_tick_s      = core_tick_r && (steps_left_r == STEP_W'(1));
        state_next_s     = state_r;
        steps_next_s     = steps_left_r;
        step_done_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stop_s) begin
                    state_next_s = ST_IDLE;
                end else if (req_s) begin
                    if (clk_mode == MODE_STEP) begin
                        steps_next_s = step_count;
                        if (step_count == {STEP_W{1'b0}}) begin
                            step_done_next_s = 1'b1;
                            state_next_s     = ST_IDLE;
                        end else begin
                            state_next_s = ST_STEP_RUN;
                        end
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEP_RUN: begin
                if (stop_s) begin
                    state_next_s = ST_IDLE;
                end else if (core_tick_r) begin
                    steps_next_s = steps_left_r - STEP_W'(1);
                    if (last_tick_s) begin
                        state_next_s     = ST_IDLE;
                        step_done_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_STEP_RUN;
                    end
                end else begin
                    state_next_s = ST_STEP_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        enable_next_s   = (state_next_s != ST_IDLE);
        core_clk_next_s = clk_src_next_s & enable_next_s;
        rise_s          = core_clk_next_s & ~core_clk_r;
    end

    // State and output registers; core_clk is gated from next-state values so it never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            start_q_r     <= 1'b0;
            mode_q_r      <= MODE_OFF;
            div_cnt_r     <= {CNT_W{1'b0}};
            clk_src_r     <= 1'b0;
            core_clk_r    <= 1'b0;
            core_tick_r   <= 1'b0;
            enable_r      <= 1'b0;
            steps_left_r  <= {STEP_W{1'b0}};
            cycle_count_r <= {CYC_W{1'b0}};
            step_done_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            start_q_r     <= start;
            mode_q_r      <= clk_mode;
            div_cnt_r     <= div_cnt_next_s;
            clk_src_r     <= clk_src_next_s;
            core_clk_r    <= core_clk_next_s;
            core_tick_r   <= rise_s;
            enable_r      <= enable_next_s;
            steps_left_r  <= steps_next_s;
            step_done_r   <= step_done_next_s;
            if (rise_s) begin
                cycle_count_r <= cycle_count_r + CYC_W'(1);
            end else begin
                cycle_count_r <= cycle_count_r;
            end
        end
    end

    assign core_clk    = core_clk_r;
    assign core_tick   = core_tick_r;
    assign enable      = enable_r;
    assign clk_src     = clk_src_r;
    assign steps_left  = steps_left_r;
    assign cycle_count = cycle_count_r;
    assign step_done   = step_done_r;

endmodule

// File: tb/tb_mu0_clock_ctrl.sv
// Directed bench for mu0_clock_ctrl: cycle-by-cycle vector table plus SLOW-divider
// and mid-run reset sequences.
module tb_mu0_clock_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  clk_mode;
    logic        start;
    logic        done;
    logic        halt_req;
    logic [31:0] slow_div;
    logic [15:0] step_count;
    logic        core_clk;
    logic        core_tick;
    logic        enable;
    logic        clk_src;
    logic [15:0] steps_left;
    logic [31:0] cycle_count;
    logic        step_done;

    int checks   = 0;
    int failures = 0;

    mu0_clock_ctrl #(
        .CNT_W(32), .STEP_W(16), .SLOW_DIV(5), .CYC_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_mode(clk_mode), .start(start),
        .done(done), .halt_req(halt_req), .slow_div(slow_div), .step_count(step_count),
        .core_clk(core_clk), .core_tick(core_tick), .enable(enable), .clk_src(clk_src),
        .steps_left(steps_left), .cycle_count(cycle_count), .step_done(step_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mode;
        logic        st;
        logic        dn;
        logic        hl;
        logic [15:0] sc;
        logic        en;
        logic        src;
        logic        core;
        logic        tick;
        logic [15:0] steps;
        logic        sdone;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [3:0] m, input logic s, input logic d, input logic h,
                                input logic [15:0] sc, input logic en, input logic src,
                                input logic core, input logic tick, input logic [15:0] steps,
                                input logic sdone, input logic [31:0] cnt);
        vec_t v;
        v.mode = m; v.st = s; v.dn = d; v.hl = h; v.sc = sc;
        v.en = en; v.src = src; v.core = core; v.tick = tick;
        v.steps = steps; v.sdone = sdone; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({enable, clk_src, core_clk, core_tick, steps_left, step_done, cycle_count});
    endfunction

    task automatic measure_slow(input string name, input int half);
        int t[3];
        int n = 0;
        logic prev = clk_src;
        for (int c = 0; c < 80 && n < 3; c++) begin
            @(posedge clk); #1;
            if (clk_src !== prev) begin
                t[n] = c;
                n++;
                prev = clk_src;
            end
        end
        check({name, "_toggles"}, 64'(n), 64'(3));
        if (n == 3) begin
            check({name, "_half1"}, 64'(t[1] - t[0]), 64'(half));
            check({name, "_half2"}, 64'(t[2] - t[1]), 64'(half));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //          mode   st    dn    hl    sc     | en   src  core tick steps  sdone cnt
        vecs[0]  = mk(4'd1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd0);
        vecs[1]  = mk(4'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd0);
        vecs[2]  = mk(4'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 32'd1);
        vecs[3]  = mk(4'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd1);
        vecs[4]  = mk(4'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 32'd2);
        vecs[5]  = mk(4'd1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd2);
        vecs[6]  = mk(4'd1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 32'd3);
        vecs[7]  = mk(4'd1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd3);
        vecs[8]  = mk(4'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd3);
        vecs[9]  = mk(4'd1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd3);
        vecs[10] = mk(4'd1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 32'd4);
        vecs[11] = mk(4'd1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd4);
        vecs[12] = mk(4'd4, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd4);
        vecs[13] = mk(4'd3, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd4);
        vecs[14] = mk(4'd4, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd4);
        vecs[15] = mk(4'd3, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd4);
        vecs[16] = mk(4'd4, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 32'd5);
        vecs[17] = mk(4'd4, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 32'd5);
        vecs[18] = mk(4'd3, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd5);
        vecs[19] = mk(4'd3, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd5);
        vecs[20] = mk(4'd5, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd5);
        vecs[21] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 32'd5);
        vecs[22] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 32'd6);
        vecs[23] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 32'd6);
        vecs[24] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 32'd7);
        vecs[25] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 32'd7);
        vecs[26] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 1'b0, 32'd8);
        vecs[27] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 32'd8);
        vecs[28] = mk(4'd5, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd8);
        vecs[29] = mk(4'd5, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 32'd8);
        vecs[30] = mk(4'd5, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd8);
        vecs[31] = mk(4'd9, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd8);
        vecs[32] = mk(4'd9, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd8);

        reset_n    = 1'b0;
        clk_mode   = 4'd0;
        start      = 1'b0;
        done       = 1'b0;
        halt_req   = 1'b0;
        slow_div   = 32'd4;
        step_count = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 64'd0);
        reset_n = 1'b1;

        // Cycle-by-cycle table: FAST run, done/halt, manual stepping, STEP runs, illegal mode.
        for (int i = 0; i < NV; i++) begin
            clk_mode   = vecs[i].mode;
            start      = vecs[i].st;
            done       = vecs[i].dn;
            halt_req   = vecs[i].hl;
            step_count = vecs[i].sc;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), outs(),
                  64'({vecs[i].en, vecs[i].src, vecs[i].core, vecs[i].tick,
                       vecs[i].steps, vecs[i].sdone, vecs[i].cnt}));
        end

        // SLOW mode: explicit divider, then fallback to the SLOW_DIV parameter.
        clk_mode = 4'd2;
        slow_div = 32'd4;
        measure_slow("slow_div4", 4);
        slow_div = 32'd0;
        measure_slow("slow_div0", 5);
        check("slow_idle_core", 64'({enable, core_clk}), 64'd0);

        // Reset in the middle of a STEP run.
        clk_mode   = 4'd5;
        step_count = 16'd5;
        start      = ~start;
        @(posedge clk); #1;
        check("step5_started", 64'({enable, steps_left}), 64'({1'b1, 16'd5}));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", outs(), 64'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset%0d", c),
                  64'({step_done, enable, core_clk, steps_left, cycle_count}), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
